pushbutton_emulator: RTL
========================

Name: pushbutton_emulator

Overview:
- Drives a pushbutton-style line from command pulses; it is the counterpart of pushbutton_processor.
- An up request becomes a short press and a down request becomes a long press, each followed by a release gap.
- Output is meant to feed a pushbutton_processor input for automated or remote score entry, and to act as the stimulus source in scoreboard system benches.
- Small command FIFO; presses are emitted strictly in request order.

Parameters:
- SHORT_MS, 100, high time of a short press, in clock cycles (1 ms each); must be >= 1.
- LONG_MS, 1500, high time of a long press, in cycles; must be > SHORT_MS and <= 65535.
- GAP_MS, 300, forced low time after every press, in cycles; must be >= 1.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk_1khz_i  input  1  1 kHz clock.
- rst_i  input  1  reset, asynchronous, active-high.
- up_req_i  input  1  one-cycle request: queue a short press.
- down_req_i  input  1  one-cycle request: queue a long press.
- pushbutton_o  output  1  emulated raw button level, active-high.
- busy_o  output  1  high while a press or gap is in progress.
- done_o  output  1  one-cycle pulse at the end of each gap.
- drop_o  output  1  one-cycle pulse when a request is discarded.
- pending_o  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, release synchronous to clk_1khz_i):
  - FSM in IDLE, FIFO empty.
  - pushbutton_o=0, busy_o=0, done_o=0, drop_o=0, pending_o=0.
  - Reset mid-press forces pushbutton_o low immediately and discards all queued commands.
- Enqueue:
  - A request sampled high at edge k is written at edge k; pending_o shows the new count after edge k.
  - Entry encoding: 0 = short, 1 = long.
  - up_req_i and down_req_i both high in the same cycle: nothing is queued, drop_o=1 for one cycle.
  - Request while FIFO full: discarded, drop_o=1 for one cycle, queue unchanged.
  - A push into a full FIFO is dropped even if a pop happens in the same cycle.
- FSM states: IDLE, PRESS, GAP. Duration counter is 16-bit.
- IDLE:
  - If FIFO is not empty, pop the head, load the counter with SHORT_MS-1 or LONG_MS-1, go to PRESS.
  - pushbutton_o=1 and busy_o=1 from the edge that performs the pop.
  - Minimum latency: request at edge k, pop at edge k+1, so pushbutton_o rises one cycle after the request was captured.
- PRESS:
  - pushbutton_o=1; counter decrements each cycle.
  - At 0, load GAP_MS-1 and go to GAP.
  - High time is exactly SHORT_MS or LONG_MS cycles.
- GAP:
  - pushbutton_o=0, busy_o=1; counter decrements.
  - At 0, go to IDLE with done_o=1 for that one cycle and busy_o=0.
  - A queued command can pop on the next edge, so the low time between presses is GAP_MS+1 cycles minimum.
- New requests are accepted in every state.
- The press in progress is never shortened or extended by new requests.
- done_o and drop_o may be asserted in the same cycle.

Optional Feature:
- Macro: PB_EMU_INVERT_EN.
- When defined: pushbutton_o is active-low. It idles high, including during reset, and is low during PRESS. This emulates a pull-up button wired to ground.
- When undefined: pushbutton_o is active-high as described above.
- All timing, FIFO and flag behaviour is identical in both builds.

Test Plan (overrides SHORT_MS=3, LONG_MS=8, GAP_MS=2, DEPTH=2 unless noted):
- Reset, then up_req_i pulse at edge 10 -> pushbutton_o high from edge 11 for exactly 3 cycles, low 2 cycles, done_o single pulse, busy_o falls with it, pending_o 1->0.
- down_req_i pulse -> pushbutton_o high exactly 8 cycles; then up_req_i during that press -> short press follows after exactly 3 low cycles (GAP_MS+1).
- Three up requests on consecutive cycles while idle -> first pops, two queue (pending_o=2), no drop; fourth request while full -> drop_o pulse, 3 presses total emitted.
- up_req_i and down_req_i high together -> drop_o=1, pending_o stays 0, pushbutton_o stays 0.
- Assert rst_i asynchronously in cycle 4 of a long press with 1 queued -> pushbutton_o=0 and pending_o=0 immediately, no press after release.
- Defaults with a pushbutton_processor instance on the output: one up request then one down request -> exactly one count_up pulse, then one count_down pulse.

Source files
------------

// File: rtl/pushbutton_emulator.sv
// Pushbutton emulator: queues up/down requests and replays them as short/long presses with a release gap.
// Define PB_EMU_INVERT_EN to make pushbutton_o active-low (idles high, low while pressed).
module pushbutton_emulator #(
  parameter int SHORT_MS = 100,
  parameter int LONG_MS  = 1500,
  parameter int GAP_MS   = 300,
  parameter int DEPTH    = 4
) (
  input  logic                     clk_1khz_i,
  input  logic                     rst_i,
  input  logic                     up_req_i,
  input  logic                     down_req_i,
  output logic                     pushbutton_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   pending_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   SHORT_LOAD = 16'(SHORT_MS - 1);
  localparam logic [15:0]   LONG_LOAD  = 16'(LONG_MS - 1);
  localparam logic [15:0]   GAP_LOAD   = 16'(GAP_MS - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic          done_nxt;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          req_one, req_both, full, empty, push, pop, head;

  // Command FIFO: 0 = short press, 1 = long press
  assign req_both = up_req_i & down_req_i;
  assign req_one  = up_req_i ^ down_req_i;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // Fullness is judged before any same-cycle pop, so a push into a full queue is always lost
  assign push     = req_one & ~full;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk_1khz_i) begin
    if (push) mem[wr_ptr] <= down_req_i;
  end

  always_ff @(posedge clk_1khz_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(push) - CW'(pop);
      drop_o <= req_both | (req_one & full);
    end
  end

  // Press sequencer
  always_ff @(posedge clk_1khz_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_o <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = head ? LONG_LOAD : SHORT_LOAD;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          cnt_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o    = (state != IDLE);
  assign pending_o = count;

`ifdef PB_EMU_INVERT_EN
  assign pushbutton_o = (state != PRESS);
`else
  assign pushbutton_o = (state == PRESS);
`endif

endmodule
